// File: rtl/uart_cmd_rx_if.sv
// Byte-in / command-out bundle for uart_cmd_rx. The block sits on the slave side.
interface uart_cmd_rx_if #(
  parameter int unsigned DP_WIDTH = 8
);
  logic [7:0]          i_rx_data;
  logic                i_rx_valid;
  logic [DP_WIDTH-1:0] o_cmd_data;
  logic [1:0]          o_cmd_reg;
  logic                o_cmd_valid;
  logic                i_cmd_rdy;
  logic                o_cmd_err;
  logic                o_rx_drop;
  logic                o_busy;

  modport master (
    output i_rx_data, i_rx_valid, i_cmd_rdy,
    input  o_cmd_data, o_cmd_reg, o_cmd_valid, o_cmd_err, o_rx_drop, o_busy
  );

  modport slave (
    input  i_rx_data, i_rx_valid, i_cmd_rdy,
    output o_cmd_data, o_cmd_reg, o_cmd_valid, o_cmd_err, o_rx_drop, o_busy
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// Parses "W<reg>:<hex digits><CR|LF>" byte streams into register-write commands
// and holds each command until the consumer accepts it.
module uart_cmd_rx #(
  parameter int unsigned DP_WIDTH = 8,
  parameter int unsigned NUM_NIB  = DP_WIDTH / 4
) (
  input  logic         clk,
  input  logic         rst,
  uart_cmd_rx_if.slave bus_io
);
  localparam int unsigned CntW = $clog2(NUM_NIB + 1);

  typedef enum logic [2:0] {StIdle, StReg, StColon, StNib, StTerm, StHold} state_e;

  state_e              state_q, state_d;
  logic [1:0]          reg_q, reg_d;
  logic [DP_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DP_WIDTH-1:0] data_q, data_d;
  logic [1:0]          creg_q, creg_d;
  logic                err_q, err_d;
  logic                drop_q, drop_d;

  logic [7:0] b;
  logic       is_w, is_term, is_digit, is_hex, bad;
  logic [3:0] nib;

  assign b        = bus_io.i_rx_data;
  assign is_w     = (b == "W") || (b == "w");
  assign is_term  = (b == 8'h0d) || (b == 8'h0a);
  assign is_digit = (b >= "0") && (b <= "3");

  // Letters map via their low nibble: 'A'/'a' = 1, plus 9 gives 10.
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'd0;
    if (b >= "0" && b <= "9") begin
      is_hex = 1'b1;
      nib    = b[3:0];
    end else if ((b >= "A" && b <= "F") || (b >= "a" && b <= "f")) begin
      is_hex = 1'b1;
      nib    = b[3:0] + 4'd9;
    end
  end

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    creg_d  = creg_q;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    bad     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.i_rx_valid && is_w) state_d = StReg;
      end
      StReg: begin
        if (bus_io.i_rx_valid) begin
          if (is_digit) begin
            reg_d   = b[1:0];
            state_d = StColon;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StColon: begin
        if (bus_io.i_rx_valid) begin
          if (b == ":") begin
            cnt_d   = '0;
            state_d = StNib;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StNib: begin
        if (bus_io.i_rx_valid) begin
          if (is_hex) begin
            shift_d = (shift_q << 4) | DP_WIDTH'(nib);
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntW'(NUM_NIB - 1)) state_d = StTerm;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StTerm: begin
        if (bus_io.i_rx_valid) begin
          if (is_term) begin
            data_d  = shift_q;
            creg_d  = reg_q;
            state_d = StHold;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StHold: begin
        // Bytes are dropped even on the accepting edge.
        drop_d = bus_io.i_rx_valid;
        if (bus_io.i_cmd_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (bad) begin
      err_d   = 1'b1;
      state_d = is_w ? StReg : StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      reg_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      creg_q  <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      creg_q  <= creg_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign bus_io.o_cmd_data  = data_q;
  assign bus_io.o_cmd_reg   = creg_q;
  assign bus_io.o_cmd_valid = (state_q == StHold);
  assign bus_io.o_cmd_err   = err_q;
  assign bus_io.o_rx_drop   = drop_q;
  assign bus_io.o_busy      = (state_q != StIdle);
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed command strings plus randomized streams, every
// cycle compared against a template-matching model of the command grammar.
module tb_uart_cmd_rx;
  localparam int unsigned DpWidth = 8;
  localparam int unsigned NumNib  = DpWidth / 4;
  localparam int unsigned CmdLen  = 4 + NumNib;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_rx_if #(.DP_WIDTH(DpWidth)) bus ();

  uart_cmd_rx #(.DP_WIDTH(DpWidth), .NUM_NIB(NumNib)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: bytes of the command in progress, and the pending/last command.
  logic [7:0]         cur_q[$];
  bit                 m_hold;
  logic [DpWidth-1:0] m_data;
  logic [1:0]         m_reg;
  bit                 m_err, m_drop;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_w(input logic [7:0] c);
    return c == "W" || c == "w";
  endfunction

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // Whether byte c may appear at position pos of "W<r>:<hex x NumNib><term>".
  function automatic bit fits(input int pos, input logic [7:0] c);
    if (pos == 1) return c >= "0" && c <= "3";
    if (pos == 2) return c == ":";
    if (pos < 3 + NumNib) return hexval(c) >= 0;
    return c == 8'h0d || c == 8'h0a;
  endfunction

  task automatic model_reset();
    cur_q.delete();
    m_hold = 0;
    m_data = '0;
    m_reg  = '0;
    m_err  = 0;
    m_drop = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] c, input bit r);
    int acc;
    m_err  = 0;
    m_drop = 0;
    if (m_hold) begin
      m_drop = v;
      if (r) m_hold = 0;
    end else if (v) begin
      if (cur_q.size() == 0) begin
        if (is_w(c)) cur_q.push_back(c);
      end else if (fits(cur_q.size(), c)) begin
        cur_q.push_back(c);
        if (cur_q.size() == CmdLen) begin
          acc = 0;
          for (int i = 0; i < NumNib; i++) acc = acc * 16 + hexval(cur_q[3 + i]);
          m_data = DpWidth'(acc);
          m_reg  = 2'(int'(cur_q[1]) - 48);
          m_hold = 1;
          cur_q.delete();
        end
      end else begin
        m_err = 1;
        cur_q.delete();
        if (is_w(c)) cur_q.push_back(c);
      end
    end
  endtask

  task automatic check_all();
    check_eq("valid", 32'(bus.o_cmd_valid), 32'(m_hold));
    check_eq("err", 32'(bus.o_cmd_err), 32'(m_err));
    check_eq("drop", 32'(bus.o_rx_drop), 32'(m_drop));
    check_eq("busy", 32'(bus.o_busy), 32'(m_hold || cur_q.size() != 0));
    check_eq("data", 32'(bus.o_cmd_data), 32'(m_data));
    check_eq("reg", 32'(bus.o_cmd_reg), 32'(m_reg));
  endtask

  task automatic cycle(input bit v, input logic [7:0] c, input bit r);
    bus.i_rx_valid = v;
    bus.i_rx_data  = v ? c : 8'($urandom);
    bus.i_cmd_rdy  = r;
    @(posedge clk);
    model_step(v, c, r);
    #1;
    check_all();
  endtask

  // Asserted just after an edge; outputs must clear without waiting for a clock.
  task automatic pulse_reset(input int cycles);
    rst = 1'b0;
    bus.i_rx_valid = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (cycles) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  task automatic send_str(input string s, input bit r);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], r);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, r);
  endtask

  task automatic send_random(input string s);
    for (int i = 0; i < s.len(); i++) begin
      while ($urandom_range(0, 3) == 0) cycle(1'b0, 8'h00, 1'($urandom));
      cycle(1'b1, s[i], 1'($urandom));
    end
  endtask

  string alphabet = "Ww0123:AaFf9c\r\nxZ";

  initial begin
    string s;
    int    k;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    bus.i_cmd_rdy  = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2, 1'b0);

    send_str("W2:A5\r", 1'b1);
    idle(2, 1'b1);
    check_eq("w2_data", 32'(bus.o_cmd_data), 32'h00A5);
    check_eq("w2_reg", 32'(bus.o_cmd_reg), 32'd2);

    send_str("w1:3c\n", 1'b1);
    idle(2, 1'b1);
    check_eq("w1_data", 32'(bus.o_cmd_data), 32'h003C);
    check_eq("w1_reg", 32'(bus.o_cmd_reg), 32'd1);

    send_str("W4", 1'b1);
    check_eq("err_reg4", 32'(bus.o_cmd_err), 32'd1);
    send_str("W1:5\r", 1'b1);
    check_eq("err_short", 32'(bus.o_cmd_err), 32'd1);
    send_str("W0:123", 1'b1);
    check_eq("err_long", 32'(bus.o_cmd_err), 32'd1);
    idle(2, 1'b1);
    check_eq("err_keep_data", 32'(bus.o_cmd_data), 32'h003C);

    send_str("W1:W", 1'b1);
    check_eq("resync_err", 32'(bus.o_cmd_err), 32'd1);
    check_eq("resync_busy", 32'(bus.o_busy), 32'd1);
    send_str("3:FF\r", 1'b1);
    idle(2, 1'b1);
    check_eq("resync_data", 32'(bus.o_cmd_data), 32'h00FF);
    check_eq("resync_reg", 32'(bus.o_cmd_reg), 32'd3);

    send_str("W0:11\r", 1'b0);
    idle(2, 1'b0);
    send_str("X", 1'b0);
    idle(1, 1'b0);
    check_eq("hold_data", 32'(bus.o_cmd_data), 32'h0011);
    check_eq("hold_valid", 32'(bus.o_cmd_valid), 32'd1);
    idle(1, 1'b1);
    check_eq("accept_valid", 32'(bus.o_cmd_valid), 32'd0);

    // Drop and acceptance on the same edge.
    send_str("W2:00\r", 1'b0);
    cycle(1'b1, "Q", 1'b1);
    idle(2, 1'b0);

    send_str("W3:7", 1'b0);
    pulse_reset(2);
    send_str("W3:77\r", 1'b0);
    idle(1, 1'b1);
    check_eq("rst_data", 32'(bus.o_cmd_data), 32'h0077);
    idle(2, 1'b0);

    pulse_reset(1);
    send_str("W1:22\r", 1'b0);
    pulse_reset(1);
    idle(2, 1'b1);

    for (int n = 0; n < 300; n++) begin
      s = $sformatf("%s%0d:%02x%s", ($urandom_range(0, 1) != 0) ? "W" : "w",
                    $urandom_range(0, 3), $urandom_range(0, 255),
                    ($urandom_range(0, 1) != 0) ? "\r" : "\n");
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, s.len() - 1);
        s.putc(k, alphabet[$urandom_range(0, alphabet.len() - 1)]);
      end
      if ($urandom_range(0, 9) == 0) s = s.substr(0, $urandom_range(0, s.len() - 2));
      send_random(s);
      if ($urandom_range(0, 29) == 0) pulse_reset($urandom_range(1, 3));
      idle($urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter DP_WIDTH, default 8, data word width in bits, a multiple of 4.
REQ-002 SHALL have parameter NUM_NIB, default DP_WIDTH/4, hex digits per command.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_rx_data  input  8  received UART byte, valid only when i_rx_valid=1.
REQ-006 SHALL have port i_rx_valid  input  1  one-cycle strobe per received byte.
REQ-007 SHALL have port o_cmd_data  output  DP_WIDTH  parsed data word.
REQ-008 SHALL have port o_cmd_reg  output  2  parsed register index.
REQ-009 SHALL have port o_cmd_valid  output  1  command available; held until accepted.
REQ-010 SHALL have port i_cmd_rdy  input  1  consumer accepts the command when o_cmd_valid=1 and i_cmd_rdy=1.
REQ-011 SHALL have port o_cmd_err  output  1  one-cycle pulse on a syntax error.
REQ-012 SHALL have port o_rx_drop  output  1  one-cycle pulse when a byte is discarded while a command is pending.
REQ-013 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL accept the grammar: 'W'|'w', reg digit '0'-'3', ':', exactly NUM_NIB hex digits ('0'-'9','A'-'F','a'-'f'), terminator '\r'|'\n'.
REQ-015 SHALL implement the states IDLE, REG, COLON, NIB, TERM and HOLD; it SHALL evaluate bytes only on cycles where i_rx_valid=1.
REQ-016 IDLE: 'W'/'w' -> REG; all other bytes, including '\r' and '\n', SHALL be ignored silently, with no error.
REQ-017 REG: a valid digit SHALL load the register latch and move to COLON; COLON: ':' -> NIB with the nibble counter cleared.
REQ-018 NIB: each hex digit SHALL shift the shift register left by 4, insert the nibble in bits [3:0] and increment the counter; after the NUM_NIB-th digit the state SHALL be TERM.
REQ-019 TERM: '\r'/'\n' SHALL copy the shift register to o_cmd_data and the latched reg to o_cmd_reg, then go to HOLD.
REQ-020 o_cmd_valid SHALL rise in the cycle after the terminator byte is sampled (1-cycle latency) and SHALL stay high in HOLD.
REQ-021 HOLD: on the edge where i_cmd_rdy=1, the block SHALL go to IDLE and o_cmd_valid SHALL be 0 next cycle; o_cmd_data and o_cmd_reg SHALL stay stable while o_cmd_valid=1 and hold their values after acceptance.
REQ-022 HOLD: any i_rx_valid byte SHALL be discarded and SHALL pulse o_rx_drop the next cycle, including when i_cmd_rdy=1 on the same edge.
REQ-023 An unexpected byte in REG, COLON, NIB or TERM SHALL pulse o_cmd_err the next cycle and leave o_cmd_data and o_cmd_valid unchanged.
REQ-024 On an error, the block SHALL go to REG if the offending byte is 'W'/'w' (resync), otherwise to IDLE.
REQ-025 A terminator arriving in NIB before NUM_NIB digits SHALL be an error; a hex digit arriving in TERM SHALL be an error.
REQ-026 The nibble counter SHALL be wide enough for NUM_NIB and SHALL never wrap within a command.
REQ-027 Hex-to-nibble conversion SHALL be case-insensitive; any non-hex byte in NIB SHALL be an error.

Reset
REQ-028 While rst=0, the block SHALL be in state IDLE with o_cmd_valid=0, o_cmd_err=0, o_rx_drop=0, o_busy=0, o_cmd_data=0, o_cmd_reg=0, and the counter and shift register cleared.
REQ-029 Reset asserted mid-command or in HOLD SHALL abandon the command immediately, without a valid or error pulse.
REQ-030 After rst deasserts, the first byte accepted SHALL be the first strobe on a clock edge at which rst=1.

Verification
REQ-031 Bench SHALL cover: "W2:A5\r" with i_cmd_rdy=1 -> one o_cmd_valid cycle, o_cmd_reg=2, o_cmd_data=8'hA5, no err.
REQ-032 Bench SHALL cover: "w1:3c\n" -> o_cmd_reg=1, o_cmd_data=8'h3C.
REQ-033 Bench SHALL cover: "W4", "W1:5\r" and "W0:123" -> o_cmd_err pulses at '4', '\r' and '3' respectively, with no o_cmd_valid.
REQ-034 Bench SHALL cover: "W1:Wx..." -> err pulse at the second 'W', state REG; then "3:FF\r" -> o_cmd_reg=3, o_cmd_data=8'hFF.
REQ-035 Bench SHALL cover: "W0:11\r" with i_cmd_rdy=0, then "X" sent -> o_rx_drop pulses once, data 8'h11 held; i_cmd_rdy=1 -> valid drops the next cycle.
REQ-036 Bench SHALL cover: "W3:7" then rst low for 2 cycles, then "W3:77\r" -> only one command, data 8'h77, no err.
